// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if: I-cache/D-cache request/response signals plus the shared AHB-Lite master pins
interface ahb_master_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_burst;
  logic        i_gnt;
  logic        i_rvalid;
  logic        i_done;
  logic        i_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic        d_burst;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic        d_wack;
  logic        d_done;
  logic        d_err;
  logic [31:0] rdata;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  modport master (
    input  i_req, i_addr, i_burst, d_req, d_addr, d_write, d_burst, d_wdata, HRDATA, HREADY, HRESP,
    output i_gnt, i_rvalid, i_done, i_err, d_gnt, d_rvalid, d_wack, d_done, d_err, rdata,
           HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE
  );
  modport slave (
    output i_req, i_addr, i_burst, d_req, d_addr, d_write, d_burst, d_wdata, HRDATA, HREADY, HRESP,
    input  i_gnt, i_rvalid, i_done, i_err, d_gnt, d_rvalid, d_wack, d_done, d_err, rdata,
           HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-Lite master port between I-cache and D-cache transactions
// Define AHB_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module ahb_master_arbiter #(
  parameter int BURST_BEATS = 8,
  parameter int BEAT_CNT_W = 4
) (
  input logic clk,
  input logic reset_n,
  ahb_master_arbiter_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;
  state_t state_q, state_d;
  logic own_d_q, own_d_d;
  logic burst_q, burst_d, hwrite_q, hwrite_d, gnt_q, gnt_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, sel_addr;
  logic [BEAT_CNT_W-1:0] iss_q, iss_d, last_beat;
  logic pick_d, in_data, fault, ok, done, err;
`ifdef AHB_ARB_RR_EN
  logic last_d_q;
  assign pick_d = bus.d_req && !(bus.i_req && last_d_q);
  always_ff @(posedge clk)
    if (!reset_n) last_d_q <= 1'b0;
    else if (state_q == S_IDLE && (bus.i_req || bus.d_req)) last_d_q <= pick_d;
`else
  assign pick_d = bus.d_req;
`endif
  assign sel_addr = pick_d ? bus.d_addr : bus.i_addr;
  assign last_beat = burst_q ? BEAT_CNT_W'(BURST_BEATS - 1) : '0;
  assign in_data = state_q == S_BURST || state_q == S_LAST;
  // first ERROR cycle: slave holds HREADY low with HRESP high
  assign fault = in_data && bus.HRESP && !bus.HREADY;
  assign ok = in_data && bus.HREADY && !bus.HRESP;
  assign err = state_q == S_ERR && bus.HREADY;
  assign done = (state_q == S_LAST && ok) || err;
  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    burst_d = burst_q;
    hwrite_d = hwrite_q;
    haddr_d = haddr_q;
    hwdata_d = hwdata_q;
    iss_d = iss_q;
    gnt_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.i_req || bus.d_req) begin
          state_d = S_ADDR;
          own_d_d = pick_d;
          burst_d = pick_d ? bus.d_burst : bus.i_burst;
          hwrite_d = pick_d && bus.d_write;
          haddr_d = sel_addr & ~32'h3;
          iss_d = '0;
          gnt_d = 1'b1;
        end
      S_ADDR, S_BURST:
        if (fault) state_d = S_ERR;
        else if (bus.HREADY) begin
          iss_d = iss_q + 1'b1;
          hwdata_d = hwrite_q ? bus.d_wdata : hwdata_q;
          state_d = iss_q == last_beat ? S_LAST : S_BURST;
          haddr_d = iss_q == last_beat ? haddr_q : haddr_q + 32'd4;
        end
      S_LAST:
        if (fault) state_d = S_ERR;
        else if (bus.HREADY) state_d = S_IDLE;
      S_ERR:
        if (bus.HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      own_d_q <= 1'b1;
      burst_q <= 1'b0;
      hwrite_q <= 1'b0;
      haddr_q <= '0;
      hwdata_q <= '0;
      iss_q <= '0;
      gnt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      burst_q <= burst_d;
      hwrite_q <= hwrite_d;
      haddr_q <= haddr_d;
      hwdata_q <= hwdata_d;
      iss_q <= iss_d;
      gnt_q <= gnt_d;
    end
  end
  assign bus.i_gnt = gnt_q && !own_d_q;
  assign bus.d_gnt = gnt_q && own_d_q;
  assign bus.i_rvalid = ok && !own_d_q;
  assign bus.d_rvalid = ok && own_d_q && !hwrite_q;
  assign bus.d_wack = ok && own_d_q && hwrite_q;
  assign bus.i_done = done && !own_d_q;
  assign bus.d_done = done && own_d_q;
  assign bus.i_err = err && !own_d_q;
  assign bus.d_err = err && own_d_q;
  assign bus.rdata = bus.HRDATA;
  assign bus.HADDR = haddr_q;
  assign bus.HBURST = !burst_q ? 3'b000 : BURST_BEATS == 4 ? 3'b011 : 3'b101;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT = {3'b001, own_d_q};
  assign bus.HSIZE = 3'b010;
  assign bus.HTRANS = state_q == S_ADDR ? 2'b10 : (state_q == S_BURST && !fault) ? 2'b11 : 2'b00;
  assign bus.HWDATA = hwdata_q;
  assign bus.HWRITE = hwrite_q;
endmodule
